sorted_pair_multiplier: RTL and testbench

//   Registered three-input magnitude comparator/sorter with product outputs.

---
 rtl/sorted_pair_multiplier.sv | 88 ++++++++
 tb/tb_sorted_pair_multiplier.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sorted_pair_multiplier.sv
// Ranks three unsigned operands into max/mid/min and registers the products
// max*mid and mid*min, one result per clock with single-cycle latency.
module sorted_pair_multiplier #(
  parameter int n = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [n-1:0]     A,
  input  logic [n-1:0]     B,
  input  logic [n-1:0]     C,
  output logic [2*n-1:0]   OUT1,
  output logic [2*n-1:0]   OUT2
);

  // Zero-extend both operands first so the product keeps every bit.
  function automatic logic [2*n-1:0] mul_full(input logic [n-1:0] x, input logic [n-1:0] y);
    logic [2*n-1:0] xe;
    logic [2*n-1:0] ye;
    xe = {{n{1'b0}}, x};
    ye = {{n{1'b0}}, y};
    return xe * ye;
  endfunction

  logic [n-1:0]   hi_ab_s;
  logic [n-1:0]   lo_ab_s;
  logic [n-1:0]   rest_s;
  logic [n-1:0]   max_s;
  logic [n-1:0]   mid_s;
  logic [n-1:0]   min_s;
  logic [2*n-1:0] out1_d;
  logic [2*n-1:0] out2_d;
  logic [2*n-1:0] out1_q;
  logic [2*n-1:0] out2_q;

  // Three-compare sorting network; ties may resolve either way since only products matter.
  always_comb begin
    hi_ab_s = A;
    lo_ab_s = B;
    max_s   = A;
    rest_s  = C;
    mid_s   = B;
    min_s   = C;
    if (A >= B) begin
      hi_ab_s = A;
      lo_ab_s = B;
    end else begin
      hi_ab_s = B;
      lo_ab_s = A;
    end
    if (hi_ab_s >= C) begin
      max_s  = hi_ab_s;
      rest_s = C;
    end else begin
      max_s  = C;
      rest_s = hi_ab_s;
    end
    if (lo_ab_s >= rest_s) begin
      mid_s = lo_ab_s;
      min_s = rest_s;
    end else begin
      mid_s = rest_s;
      min_s = lo_ab_s;
    end
  end

  // Next-state products; reset wins over the sample taken on the same edge.
  always_comb begin
    out1_d = {(2*n){1'b0}};
    out2_d = {(2*n){1'b0}};
    if (rst) begin
      out1_d = {(2*n){1'b0}};
      out2_d = {(2*n){1'b0}};
    end else begin
      out1_d = mul_full(max_s, mid_s);
      out2_d = mul_full(mid_s, min_s);
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    out1_q <= out1_d;
    out2_q <= out2_d;
  end

  assign OUT1 = out1_q;
  assign OUT2 = out2_q;

endmodule

// File: tb/tb_sorted_pair_multiplier.sv
// Directed and random checks of sorted_pair_multiplier against a sort-then-multiply
// reference, using a queue of expected output pairs.
module tb_sorted_pair_multiplier;

  localparam int N = 5;

  typedef struct {
    string          tag;
    logic [2*N-1:0] e1;
    logic [2*N-1:0] e2;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [N-1:0]   c;
  logic [2*N-1:0] out1;
  logic [2*N-1:0] out2;

  exp_t sb[$];
  int   total;
  int   passed;
  int   failed;

  sorted_pair_multiplier #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .C   (c),
    .OUT1(out1),
    .OUT2(out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bubble-sort a small array descending, then multiply.
  function automatic exp_t model(input string tag, input int x, input int y, input int z, input bit r);
    int   v[3];
    int   t;
    exp_t e;
    v[0] = x; v[1] = y; v[2] = z;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2 - i; j++)
        if (v[j] < v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    e.tag = tag;
    if (r) begin
      e.e1 = '0;
      e.e2 = '0;
    end else begin
      e.e1 = (2*N)'(v[0] * v[1]);
      e.e2 = (2*N)'(v[1] * v[2]);
    end
    return e;
  endfunction

  task automatic check_pair(input string tag, input logic [2*N-1:0] e1, input logic [2*N-1:0] e2);
    total++;
    assert (out1 === e1) passed++;
    else begin
      failed++;
      $error("FAIL %s OUT1 observed=%0d expected=%0d", tag, out1, e1);
    end
    total++;
    assert (out2 === e2) passed++;
    else begin
      failed++;
      $error("FAIL %s OUT2 observed=%0d expected=%0d", tag, out2, e2);
    end
  endtask

  // Drive one sample, clock it, and compare against the oldest queued expectation.
  task automatic step(input string tag, input int x, input int y, input int z, input bit r);
    exp_t e;
    a = N'(x); b = N'(y); c = N'(z); rst = r;
    sb.push_back(model(tag, x, y, z, r));
    @(posedge clk);
    #1;
    total++;
    assert (sb.size() > 0) passed++;
    else begin
      failed++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_pair(e.tag, e.e1, e.e2);
    end
  endtask

  initial begin
    int perm[6][3];
    int x, y, z;
    total = 0; passed = 0; failed = 0;
    rst = 1'b1; a = '0; b = '0; c = '0;

    // Reset state
    step("reset", 0, 0, 0, 1'b1);
    check_pair("reset_const", 10'd0, 10'd0);

    // All six orderings of 3,7,5 give 35/15
    perm[0] = '{3, 7, 5}; perm[1] = '{3, 5, 7}; perm[2] = '{7, 3, 5};
    perm[3] = '{7, 5, 3}; perm[4] = '{5, 3, 7}; perm[5] = '{5, 7, 3};
    for (int i = 0; i < 6; i++) begin
      step($sformatf("perm%0d", i), perm[i][0], perm[i][1], perm[i][2], 1'b0);
      check_pair($sformatf("perm%0d_const", i), 10'd35, 10'd15);
    end

    // Ties, zeros, width
    step("tie662", 6, 6, 2, 1'b0);      check_pair("tie662_const", 10'd36, 10'd12);
    step("all31", 31, 31, 31, 1'b0);    check_pair("all31_const", 10'd961, 10'd961);
    step("zero094", 0, 9, 4, 1'b0);     check_pair("zero094_const", 10'd36, 10'd0);
    step("zero0017", 0, 0, 17, 1'b0);   check_pair("zero0017_const", 10'd0, 10'd0);
    step("upper", 31, 30, 29, 1'b0);    check_pair("upper_const", 10'd930, 10'd870);

    // Reset held with live inputs, release, then mid-stream reset
    for (int i = 0; i < 3; i++) begin
      step($sformatf("rsthold%0d", i), 3, 7, 5, 1'b1);
      check_pair($sformatf("rsthold%0d_const", i), 10'd0, 10'd0);
    end
    step("release", 3, 7, 5, 1'b0);     check_pair("release_const", 10'd35, 10'd15);
    step("stream", 31, 30, 29, 1'b0);   check_pair("stream_const", 10'd930, 10'd870);
    step("midrst", 31, 30, 29, 1'b1);   check_pair("midrst_const", 10'd0, 10'd0);
    step("after", 6, 6, 2, 1'b0);       check_pair("after_const", 10'd36, 10'd12);

    // Random triples
    for (int i = 0; i < 20; i++) begin
      x = int'($urandom_range(0, 31));
      y = int'($urandom_range(0, 31));
      z = int'($urandom_range(0, 31));
      step($sformatf("rand%0d_%0d_%0d_%0d", i, x, y, z), x, y, z, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
